// File: rtl/x_uart_pkg.sv
// x_uart_pkg: shared definitions for the x_uart_periph memory-mapped UART.
//   - register offsets within the 16-byte window
//   - STATUS register bit positions
//   - TX and RX serializer state encodings
package x_uart_pkg;

    localparam logic [3:0] REG_TXDATA = 4'h0;
    localparam logic [3:0] REG_RXDATA = 4'h4;
    localparam logic [3:0] REG_STATUS = 4'h8;
    localparam logic [3:0] REG_BAUD   = 4'hC;

    localparam int unsigned ST_TX_FULL    = 0;
    localparam int unsigned ST_TX_EMPTY   = 1;
    localparam int unsigned ST_RX_EMPTY   = 2;
    localparam int unsigned ST_RX_OVERRUN = 3;
    localparam int unsigned ST_TX_BUSY    = 4;
    localparam int unsigned ST_FRAME_ERR  = 5;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/x_uart_fifo.sv
// x_uart_fifo: synchronous FIFO with full/empty flags.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset (empties the FIFO)
//   i_push, i_data write request and data; ignored when full unless popping too
//   i_pop          read request; ignored when empty
//   o_data         head entry (valid when not empty)
//   o_full, o_empty occupancy flags
// WIDTH is the entry width; DEPTH must be a power of 2 and at least 2.
module x_uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    // A pop frees a slot in the same cycle, so push+pop on a full FIFO both happen.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/x_uart_periph.sv
// x_uart_periph: memory-mapped UART slave on the core's valid/rnw/addr/data bus.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_valid, i_rnw      request valid (held until accepted), 1 = read
//   i_addr, i_data      byte address (bits [1:0] ignored), write data
//   o_accept, o_hit     request completes / request targets this window
//   o_data              read data, 0 unless o_hit
//   i_rx, o_tx          serial receive (asynchronous) and transmit lines
// Registers: 0x0 TXDATA, 0x4 RXDATA, 0x8 STATUS, 0xC BAUD (clocks per bit - 1).
// Build option X_UART_RX_EN: when defined the receiver and RX FIFO are built;
// otherwise RXDATA reads all-ones and STATUS reports the RX FIFO as empty.
module x_uart_periph
    import x_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_rnw,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    output logic        o_accept,
    output logic        o_hit,
    output logic [31:0] o_data,
    input  logic        i_rx,
    output logic        o_tx
);

    logic [3:0]  w_off;
    logic        w_hit;
    logic        w_wr_tx;
    logic        w_tx_push;
    logic        w_tx_pop;
    logic        w_tx_full;
    logic        w_tx_empty;
    logic [7:0]  w_tx_fifo_data;
    logic        w_rx_empty;
    logic [7:0]  w_rx_data;
    logic        w_rx_ovr;
    logic        w_rx_ferr;
    logic [31:0] w_status;
    logic [15:0] r_baud;
    logic        w_unused;

    assign w_off    = {i_addr[3:2], 2'b00};
    assign w_hit    = i_valid & (i_addr[31:4] == BASE_ADDR[31:4]);
    assign w_wr_tx  = w_hit & ~i_rnw & (w_off == REG_TXDATA);
    assign o_hit    = w_hit;
    assign o_accept = w_hit & ~(w_wr_tx & w_tx_full);
    assign w_tx_push = w_wr_tx & ~w_tx_full;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_baud <= 16'(CLKS_PER_BIT - 1);
        end else if (w_hit && !i_rnw && (w_off == REG_BAUD)) begin
            r_baud <= i_data[15:0];
        end
    end

    // ---------------- transmitter ----------------
    tx_state_t  r_tx_state, w_tx_state_nxt;
    logic [15:0] r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0]  r_tx_bit, w_tx_bit_nxt;
    logic [7:0]  r_tx_shift, w_tx_shift_nxt;
    logic        r_tx, w_tx_nxt;

    x_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_tx_push),
        .i_data  (i_data[7:0]),
        .i_pop   (w_tx_pop),
        .o_data  (w_tx_fifo_data),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    // The bit counter reloads from BAUD at each boundary so a BAUD write
    // applies from the next bit on.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_nxt       = r_tx;
        w_tx_pop       = 1'b0;
        unique case (r_tx_state)
            TX_IDLE: begin
                if (!w_tx_empty) begin
                    w_tx_pop       = 1'b1;
                    w_tx_shift_nxt = w_tx_fifo_data;
                    w_tx_cnt_nxt   = r_baud;
                    w_tx_nxt       = 1'b0;
                    w_tx_state_nxt = TX_START;
                end
            end
            TX_START: begin
                if (r_tx_cnt != '0) begin
                    w_tx_cnt_nxt = r_tx_cnt - 16'd1;
                end else begin
                    w_tx_cnt_nxt   = r_baud;
                    w_tx_bit_nxt   = 3'd0;
                    w_tx_nxt       = r_tx_shift[0];
                    w_tx_state_nxt = TX_DATA;
                end
            end
            TX_DATA: begin
                if (r_tx_cnt != '0) begin
                    w_tx_cnt_nxt = r_tx_cnt - 16'd1;
                end else begin
                    w_tx_cnt_nxt = r_baud;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_nxt       = 1'b1;
                        w_tx_state_nxt = TX_STOP;
                    end else begin
                        w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                        w_tx_nxt       = r_tx_shift[1];
                        w_tx_bit_nxt   = r_tx_bit + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (r_tx_cnt != '0) begin
                    w_tx_cnt_nxt = r_tx_cnt - 16'd1;
                end else if (!w_tx_empty) begin
                    // Chain straight into the next start bit, no idle gap.
                    w_tx_pop       = 1'b1;
                    w_tx_shift_nxt = w_tx_fifo_data;
                    w_tx_cnt_nxt   = r_baud;
                    w_tx_nxt       = 1'b0;
                    w_tx_state_nxt = TX_START;
                end else begin
                    w_tx_nxt       = 1'b1;
                    w_tx_state_nxt = TX_IDLE;
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

    assign o_tx = r_tx;

    // ---------------- receiver ----------------
`ifdef X_UART_RX_EN
    rx_state_t   r_rx_state, w_rx_state_nxt;
    logic [15:0] r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0]  r_rx_bit, w_rx_bit_nxt;
    logic [7:0]  r_rx_shift, w_rx_shift_nxt;
    logic        r_rx_s1, r_rx_s2, r_rx_prev;
    logic        r_rx_ovr, r_rx_ferr;
    logic        w_rx_push, w_rx_pop, w_rx_full, w_ferr_set;
    logic        w_rd_rx, w_rd_status;

    assign w_rd_rx     = w_hit & i_rnw & (w_off == REG_RXDATA);
    assign w_rd_status = w_hit & i_rnw & (w_off == REG_STATUS);
    assign w_rx_pop    = w_rd_rx & ~w_rx_empty;

    x_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_rx_push),
        .i_data  (r_rx_shift),
        .i_pop   (w_rx_pop),
        .o_data  (w_rx_data),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_ovr   <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_rx_s1    <= i_rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            // A new event in the same cycle as the clearing read wins.
            r_rx_ovr   <= (r_rx_ovr & ~w_rd_status) | (w_rx_push & w_rx_full & ~w_rx_pop);
            r_rx_ferr  <= (r_rx_ferr & ~w_rd_status) | w_ferr_set;
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_push      = 1'b0;
        w_ferr_set     = 1'b0;
        unique case (r_rx_state)
            RX_IDLE: begin
                if (r_rx_prev && !r_rx_s2) begin
                    w_rx_cnt_nxt   = r_baud >> 1;
                    w_rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (r_rx_cnt != '0) begin
                    w_rx_cnt_nxt = r_rx_cnt - 16'd1;
                end else if (r_rx_s2) begin
                    w_rx_state_nxt = RX_IDLE;  // glitch, not a start bit
                end else begin
                    w_rx_cnt_nxt   = r_baud;
                    w_rx_bit_nxt   = 3'd0;
                    w_rx_state_nxt = RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt != '0) begin
                    w_rx_cnt_nxt = r_rx_cnt - 16'd1;
                end else begin
                    w_rx_shift_nxt = {r_rx_s2, r_rx_shift[7:1]};
                    w_rx_cnt_nxt   = r_baud;
                    if (r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
                    else                  w_rx_bit_nxt   = r_rx_bit + 3'd1;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt != '0) begin
                    w_rx_cnt_nxt = r_rx_cnt - 16'd1;
                end else begin
                    if (r_rx_s2) w_rx_push  = 1'b1;
                    else         w_ferr_set = 1'b1;
                    w_rx_state_nxt = RX_IDLE;
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    assign w_rx_ovr  = r_rx_ovr;
    assign w_rx_ferr = r_rx_ferr;
    assign w_unused  = ^{i_addr[1:0], i_data[31:16]};
`else
    assign w_rx_empty = 1'b1;
    assign w_rx_data  = 8'hFF;
    assign w_rx_ovr   = 1'b0;
    assign w_rx_ferr  = 1'b0;
    assign w_unused   = ^{i_addr[1:0], i_data[31:16], i_rx};
`endif

    // ---------------- read mux ----------------
    always_comb begin
        w_status = '0;
        w_status[ST_TX_FULL]    = w_tx_full;
        w_status[ST_TX_EMPTY]   = w_tx_empty;
        w_status[ST_RX_EMPTY]   = w_rx_empty;
        w_status[ST_RX_OVERRUN] = w_rx_ovr;
        w_status[ST_TX_BUSY]    = (r_tx_state != TX_IDLE);
        w_status[ST_FRAME_ERR]  = w_rx_ferr;
    end

    always_comb begin
        o_data = '0;
        if (w_hit && i_rnw) begin
            case (w_off)
                REG_RXDATA: o_data = w_rx_empty ? 32'hFFFF_FFFF : {24'd0, w_rx_data};
                REG_STATUS: o_data = w_status;
                REG_BAUD:   o_data = {16'd0, r_baud};
                default:    o_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_x_uart_periph.sv
module tb_x_uart_periph;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        i_rnw;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        o_accept;
    logic        o_hit;
    logic [31:0] o_data;
    logic        i_rx;
    logic        o_tx;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] burst [6] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    logic [7:0] ovr_b [5] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};

    always #5 i_clk = ~i_clk;

    x_uart_periph #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (16),
        .FIFO_DEPTH   (4)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .i_rnw    (i_rnw),
        .i_addr   (i_addr),
        .i_data   (i_data),
        .o_accept (o_accept),
        .o_hit    (o_hit),
        .o_data   (o_data),
        .i_rx     (i_rx),
        .o_tx     (o_tx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Advance n clocks; returns 1 time unit after the rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic bus_rd(input logic [31:0] addr, input string tag, input logic [31:0] exp);
        i_valid = 1'b1; i_rnw = 1'b1; i_addr = addr; i_data = '0;
        #1;
        check({tag, "_acc"}, {31'd0, o_accept}, 32'd1);
        check(tag, o_data, exp);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, input string tag);
        i_valid = 1'b1; i_rnw = 1'b0; i_addr = addr; i_data = data;
        #1;
        check(tag, {31'd0, o_accept}, 32'd1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Expects a full 10-bit frame on o_tx starting at the current cycle.
    task automatic expect_frame(input logic [7:0] b, input int bit_cycles);
        logic [9:0] bits;
        int bad;
        bits = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            bad = 0;
            for (int c = 0; c < bit_cycles; c++) begin
                if (o_tx !== bits[k]) bad++;
                cyc(1);
            end
            check($sformatf("tx_%02h_bit%0d", b, k), 32'(bad), 32'd0);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        i_rx = 1'b0;
        cyc(16);
        for (int k = 0; k < 8; k++) begin
            i_rx = b[k];
            cyc(16);
        end
        i_rx = stop;
        cyc(16);
        i_rx = 1'b1;
        cyc(4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        i_rst = 1'b1; i_valid = 1'b0; i_rnw = 1'b0; i_addr = '0; i_data = '0; i_rx = 1'b1;
        cyc(3);
        check("rst_tx", {31'd0, o_tx}, 32'd1);
        i_rst = 1'b0;
        cyc(2);

        // Reset state and window decode
        check("idle_accept", {31'd0, o_accept}, 32'd0);
        check("idle_hit", {31'd0, o_hit}, 32'd0);
        check("idle_data", o_data, 32'd0);
        check("idle_tx", {31'd0, o_tx}, 32'd1);
        bus_rd(BASE + 32'h8, "status_rst", 32'h06);
        bus_rd(BASE + 32'hC, "baud_rst", 32'h0F);
        bus_rd(BASE + 32'h0, "txdata_rd", 32'h0);
        i_valid = 1'b1; i_rnw = 1'b1; i_addr = 32'h2000_0008;
        #1;
        check("miss_hit", {31'd0, o_hit}, 32'd0);
        check("miss_accept", {31'd0, o_accept}, 32'd0);
        check("miss_data", o_data, 32'd0);
        cyc(1);
        i_valid = 1'b0;
        bus_wr(BASE + 32'h8, 32'hFF, "status_wr_acc");
        bus_rd(BASE + 32'h8, "status_wr_ignored", 32'h06);

        // Single frame 0x55: start bit begins two cycles after the accept
        bus_wr(BASE, 32'h55, "tx55_acc");
        check("tx55_n1_idle", {31'd0, o_tx}, 32'd1);
        cyc(1);
        expect_frame(8'h55, 16);
        check("tx55_after", {31'd0, o_tx}, 32'd1);
        cyc(2);
        bus_rd(BASE + 32'h8, "status_after55", 32'h06);

        // Six back-to-back writes into a 4-deep FIFO
        fork
            begin
                int cyc_n;
                cyc_n = 0;
                for (int i = 0; i < 6; i++) begin
                    i_valid = 1'b1; i_rnw = 1'b0; i_addr = BASE; i_data = {24'd0, burst[i]};
                    #1;
                    if (i < 5) begin
                        check($sformatf("burst_acc%0d", i), {31'd0, o_accept}, 32'd1);
                    end else begin
                        check("burst_hit5", {31'd0, o_hit}, 32'd1);
                        check("burst_stall5", {31'd0, o_accept}, 32'd0);
                        while (!o_accept && cyc_n < 400) begin
                            @(posedge i_clk);
                            #1;
                            cyc_n++;
                            #1;
                        end
                        check("burst_acc5_cycle", 32'(cyc_n), 32'd162);
                    end
                    @(posedge i_clk);
                    #1;
                    cyc_n++;
                end
                i_valid = 1'b0;
            end
            begin
                cyc(2);
                for (int i = 0; i < 6; i++) expect_frame(burst[i], 16);
            end
        join
        check("burst_end_tx", {31'd0, o_tx}, 32'd1);
        cyc(2);
        bus_rd(BASE + 32'h8, "status_after_burst", 32'h06);

`ifdef X_UART_RX_EN
        // Receive one byte
        send_rx(8'hA5, 1'b1);
        bus_rd(BASE + 32'h8, "rx_status", 32'h02);
        bus_rd(BASE + 32'h4, "rx_data_a5", 32'h0000_00A5);
        bus_rd(BASE + 32'h4, "rx_data_empty", 32'hFFFF_FFFF);

        // Overrun: fifth byte dropped
        for (int i = 0; i < 5; i++) send_rx(ovr_b[i], 1'b1);
        bus_rd(BASE + 32'h8, "ovr_status", 32'h0A);
        for (int i = 0; i < 4; i++) bus_rd(BASE + 32'h4, $sformatf("ovr_rd%0d", i),
                                           {24'd0, ovr_b[i]});
        bus_rd(BASE + 32'h4, "ovr_rd_empty", 32'hFFFF_FFFF);
        bus_rd(BASE + 32'h8, "ovr_status_clr", 32'h06);

        // Framing error
        send_rx(8'h3C, 1'b0);
        bus_rd(BASE + 32'h8, "ferr_status", 32'h26);
        bus_rd(BASE + 32'h8, "ferr_status_clr", 32'h06);
        bus_rd(BASE + 32'h4, "ferr_no_byte", 32'hFFFF_FFFF);
`else
        bus_rd(BASE + 32'h4, "norx_rxdata", 32'hFFFF_FFFF);
        send_rx(8'hA5, 1'b1);
        bus_rd(BASE + 32'h8, "norx_status", 32'h06);
        bus_rd(BASE + 32'h4, "norx_rxdata2", 32'hFFFF_FFFF);
`endif

        // BAUD=7 then reset in the middle of a frame
        bus_wr(BASE + 32'hC, 32'h7, "baud_wr");
        bus_rd(BASE + 32'hC, "baud_rd7", 32'h7);
        bus_wr(BASE, 32'h01, "tx01_acc");
        cyc(1);
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            if (o_tx !== 1'b0) bad++;
            cyc(1);
        end
        check("baud7_start", 32'(bad), 32'd0);
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            if (o_tx !== 1'b1) bad++;
            cyc(1);
        end
        check("baud7_bit0", 32'(bad), 32'd0);
        bus_rd(BASE + 32'h8, "status_busy", 32'h16);
        check("baud7_bit1", {31'd0, o_tx}, 32'd0);
        i_rst = 1'b1;
        #1;
        check("rst_async_tx", {31'd0, o_tx}, 32'd1);
        cyc(2);
        i_rst = 1'b0;
        cyc(1);
        bus_rd(BASE + 32'h8, "status_post_rst", 32'h06);
        bus_rd(BASE + 32'hC, "baud_post_rst", 32'h0F);
        cyc(20);
        check("tx_quiet_post_rst", {31'd0, o_tx}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
